// File: rtl/imm_pick.sv
// Immediate generator: rebuilds the sign-extended RV32 immediate (I/S/U/B/J) from the instruction word.
// Latency: 1 cycle; the decoded immediate is captured on every rising edge of CLK.
// Backpressure: none; there is no enable or handshake, and a new value is taken every cycle.
module imm_pick (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic [2:0]  IMM_PICK,
  output logic [31:0] IMMEDIATE
);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_U = 3'b010,
    FMT_B = 3'b011,
    FMT_J = 3'b100
  } fmt_e;

  logic [31:0] imm_d;
  logic [31:0] imm_q;
  logic        sign;

  // The sign bit of every sign-extended format is the instruction MSB.
  assign sign = INSTRUCTION[31];

  // Pure combinational field reassembly for the selected format; reserved selects give zero.
  always_comb begin
    imm_d = 32'h0000_0000;
    case (IMM_PICK)
      FMT_I: imm_d = {{20{sign}}, INSTRUCTION[31:20]};
      FMT_S: imm_d = {{20{sign}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
      FMT_U: imm_d = {INSTRUCTION[31:12], 12'h000};
      FMT_B: imm_d = {{19{sign}}, sign, INSTRUCTION[7], INSTRUCTION[30:25],
                      INSTRUCTION[11:8], 1'b0};
      FMT_J: imm_d = {{11{sign}}, sign, INSTRUCTION[19:12], INSTRUCTION[20],
                      INSTRUCTION[30:21], 1'b0};
      default: imm_d = 32'h0000_0000;
    endcase
  end

  // Output register; reset wins over any input combination.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      imm_q <= 32'h0000_0000;
    end else begin
      imm_q <= imm_d;
    end
  end

  assign IMMEDIATE = imm_q;

endmodule

// File: tb/tb_imm_pick.sv
// Bench for imm_pick: directed vectors with literal expectations plus an arithmetic reference model.
// The model predicts the registered immediate one edge after the inputs are sampled.
// Every negedge after the first reset edge the DUT output is compared against the model.
module tb_imm_pick;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [2:0]  IMM_PICK;
  logic [31:0] IMMEDIATE;

  int checks;
  int errors;

  logic [31:0] exp_q;
  logic        exp_vld;

  imm_pick dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .INSTRUCTION(INSTRUCTION),
    .IMM_PICK   (IMM_PICK),
    .IMMEDIATE  (IMMEDIATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: immediates as two's-complement sums of weighted fields.
  function automatic logic [31:0] model(input logic [31:0] inst, input logic [2:0] sel);
    int v;
    int neg;
    neg = inst[31] ? 1 : 0;
    case (sel)
      3'd0: v = -(neg * 2048) + int'(inst[30:20]);
      3'd1: v = -(neg * 2048) + (int'(inst[30:25]) * 32) + int'(inst[11:7]);
      3'd2: v = int'(inst & 32'hFFFF_F000);
      3'd3: v = -(neg * 4096) + (int'(inst[7]) * 2048) + (int'(inst[30:25]) * 32)
                + (int'(inst[11:8]) * 2);
      3'd4: v = -(neg * 1048576) + (int'(inst[19:12]) * 4096) + (int'(inst[20]) * 2048)
                + (int'(inst[30:21]) * 2);
      default: v = 0;
    endcase
    return v;
  endfunction

  // Model register: mirrors what the output must hold after each edge.
  always @(posedge CLK) begin
    if (RESET) begin
      exp_q   <= 32'h0;
      exp_vld <= 1'b1;
    end else begin
      exp_q <= model(INSTRUCTION, IMM_PICK);
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge CLK) begin
    if (exp_vld === 1'b1) begin
      checks++;
      if (IMMEDIATE !== exp_q) begin
        errors++;
        $display("FAIL model_cmp: got %h expected %h (t=%0t)", IMMEDIATE, exp_q, $time);
      end
    end
  end

  // Apply one vector at a negedge, then check the literal one edge later.
  task automatic apply(input string name, input logic rst, input logic [31:0] inst,
                       input logic [2:0] sel, input logic [31:0] lit);
    RESET       = rst;
    INSTRUCTION = inst;
    IMM_PICK    = sel;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (IMMEDIATE !== lit) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, IMMEDIATE, lit);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_vld     = 1'b0;
    exp_q       = 32'h0;
    RESET       = 1'b1;
    INSTRUCTION = 32'h0;
    IMM_PICK    = 3'd0;
    @(negedge CLK);

    apply("reset",        1'b1, 32'hFFFF_FFFF, 3'b000, 32'h0000_0000);
    apply("post_reset",   1'b0, 32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF);
    apply("i_neg",        1'b0, 32'hFFF0_0000, 3'b000, 32'hFFFF_FFFF);
    apply("i_zero",       1'b0, 32'h000F_FFFF, 3'b000, 32'h0000_0000);
    apply("s_neg",        1'b0, 32'hFE00_0F80, 3'b001, 32'hFFFF_FFFF);
    apply("s_zero",       1'b0, 32'h01FF_F07F, 3'b001, 32'h0000_0000);
    apply("u_ones",       1'b0, 32'hFFFF_F000, 3'b010, 32'hFFFF_F000);
    apply("u_zero",       1'b0, 32'h0000_0FFF, 3'b010, 32'h0000_0000);
    apply("b_neg",        1'b0, 32'hFE00_0F80, 3'b011, 32'hFFFF_FFFE);
    apply("b_zero",       1'b0, 32'h01FF_F07F, 3'b011, 32'h0000_0000);
    apply("j_mix",        1'b0, 32'h8765_4321, 3'b100, 32'hFFF5_4076);
    apply("rsv_101",      1'b0, 32'hFFFF_FFFF, 3'b101, 32'h0000_0000);
    apply("rsv_110",      1'b0, 32'h8765_4321, 3'b110, 32'h0000_0000);
    apply("rsv_111",      1'b0, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000);
    // Positive cases with distinctive field values.
    apply("i_pos",        1'b0, 32'h7FF0_0013, 3'b000, 32'h0000_07FF);
    apply("u_pos",        1'b0, 32'h1234_5037, 3'b010, 32'h1234_5000);
    apply("j_pos",        1'b0, 32'h0010_006F, 3'b100, 32'h0000_0800);
    apply("b_bit11",      1'b0, 32'h0000_0080, 3'b011, 32'h0000_0800);
    // Back-to-back format changes on the same word: no stale values.
    apply("b2b_i",        1'b0, 32'h8765_4321, 3'b000, 32'hFFFF_F876);
    apply("b2b_s",        1'b0, 32'h8765_4321, 3'b001, 32'hFFFF_F866);
    apply("b2b_u",        1'b0, 32'h8765_4321, 3'b010, 32'h8765_4000);
    apply("b2b_b",        1'b0, 32'h8765_4321, 3'b011, 32'hFFFF_F066);
    // Reset mid-stream has priority, then normal capture resumes.
    apply("mid_reset",    1'b1, 32'hFFF0_0000, 3'b000, 32'h0000_0000);
    apply("after_reset",  1'b0, 32'hFFF0_0000, 3'b000, 32'hFFFF_FFFF);

    // Mid-cycle input change: only the value present at the edge matters.
    RESET       = 1'b0;
    INSTRUCTION = 32'hFFFF_F000;
    IMM_PICK    = 3'b010;
    #2;
    INSTRUCTION = 32'h0000_0FFF;
    @(posedge CLK);
    #1;
    INSTRUCTION = 32'hFFFF_FFFF;
    IMM_PICK    = 3'b000;
    @(negedge CLK);
    checks++;
    if (IMMEDIATE !== 32'h0000_0000) begin
      errors++;
      $display("FAIL hold_between_edges: got %h expected %h", IMMEDIATE, 32'h0000_0000);
    end

    // Pseudo-random traffic checked by the model every cycle.
    for (int i = 0; i < 200; i++) begin
      RESET       = ($urandom_range(0, 31) == 0);
      INSTRUCTION = $urandom;
      IMM_PICK    = 3'($urandom_range(0, 7));
      @(negedge CLK);
    end
    RESET = 1'b0;
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
